// File: rtl/pipe_ctrl_unit.sv
// Registered main-control unit: decodes the ID opcode into a control word launched into ID/EX,
// with load-use stall, redirect flush and a counted multi-cycle MUL/DIV hold.
module pipe_ctrl_unit #(
   parameter int REG_ADDR_W = 5,
   parameter bit MULDIV_EN  = 1'b1,
   parameter int MULDIV_LAT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [6:0]            opcode,
   input  logic [6:0]            funct7,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  ex_redirect,
   output logic                  ex_valid,
   output logic                  ex_alusrc,
   output logic                  ex_memtoreg,
   output logic                  ex_regwrite,
   output logic                  ex_memread,
   output logic                  ex_memwrite,
   output logic                  ex_branch,
   output logic                  ex_jump,
   output logic                  ex_jalr,
   output logic                  ex_muldiv,
   output logic [1:0]            ex_aluop,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  stall,
   output logic                  flush_ifid,
   output logic                  illegal
);
   localparam int CNT_W = $clog2(MULDIV_LAT) + 1;

   typedef enum logic {RUN, MD_BUSY} state_t;

   typedef struct packed {
      logic                  valid;
      logic                  alusrc;
      logic                  memtoreg;
      logic                  regwrite;
      logic                  memread;
      logic                  memwrite;
      logic                  branch;
      logic                  jump;
      logic                  jalr;
      logic                  muldiv;
      logic                  illegal;
      logic [1:0]            aluop;
      logic [REG_ADDR_W-1:0] rd;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d, dec;

   logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc, known;
   logic uses_rs2, load_use;

   assign is_r     = (opcode == 7'b0110011);
   assign is_i     = (opcode == 7'b0010011);
   assign is_lw    = (opcode == 7'b0000011);
   assign is_sw    = (opcode == 7'b0100011);
   assign is_br    = (opcode == 7'b1100011);
   assign is_jal   = (opcode == 7'b1101111);
   assign is_jalr  = (opcode == 7'b1100111);
   assign is_lui   = (opcode == 7'b0110111);
   assign is_auipc = (opcode == 7'b0010111);
   assign known    = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui | is_auipc;
   assign uses_rs2 = is_r | is_sw | is_br;

   always_comb begin
      dec          = '0;
      dec.valid    = 1'b1;
      dec.rd       = rd;
      dec.alusrc   = is_lw | is_sw | is_i | is_lui | is_auipc | is_jalr;
      dec.regwrite = is_r | is_i | is_lw | is_jal | is_jalr | is_lui | is_auipc;
      dec.memread  = is_lw;
      dec.memtoreg = is_lw;
      dec.memwrite = is_sw;
      dec.branch   = is_br;
      dec.jump     = is_jal | is_jalr;
      dec.jalr     = is_jalr;
      dec.muldiv   = is_r & (funct7 == 7'b0000001) & MULDIV_EN;
      dec.illegal  = ~known;
      if (is_br)                 dec.aluop = 2'b01;
      else if (is_r | is_i)      dec.aluop = 2'b10;
      else if (is_jal | is_jalr) dec.aluop = 2'b11;
      else                       dec.aluop = 2'b00;
   end

   assign load_use = id_valid & ctrl_q.valid & ctrl_q.memread & (|ctrl_q.rd) &
                     ((ctrl_q.rd == rs1) | (uses_rs2 & (ctrl_q.rd == rs2)));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ctrl_d     = ctrl_q;
      stall      = 1'b0;
      flush_ifid = 1'b0;
      case (state_q)
         RUN: begin
            ctrl_d = '0;
            // redirect wins over a load-use hazard: the dependent op is squashed anyway
            if (ex_redirect) begin
               flush_ifid = 1'b1;
            end else if (load_use) begin
               stall = 1'b1;
            end else if (id_valid) begin
               ctrl_d = dec;
               if (dec.muldiv && (MULDIV_LAT > 1)) begin
                  state_d = MD_BUSY;
                  cnt_d   = CNT_W'(MULDIV_LAT - 1);
               end
            end
         end
         MD_BUSY: begin
            stall = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (!reset) begin
         stall      = 1'b0;
         flush_ifid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign ex_valid    = ctrl_q.valid;
   assign ex_alusrc   = ctrl_q.alusrc;
   assign ex_memtoreg = ctrl_q.memtoreg;
   assign ex_regwrite = ctrl_q.regwrite;
   assign ex_memread  = ctrl_q.memread;
   assign ex_memwrite = ctrl_q.memwrite;
   assign ex_branch   = ctrl_q.branch;
   assign ex_jump     = ctrl_q.jump;
   assign ex_jalr     = ctrl_q.jalr;
   assign ex_muldiv   = ctrl_q.muldiv;
   assign ex_aluop    = ctrl_q.aluop;
   assign ex_rd       = ctrl_q.rd;
   assign illegal     = ctrl_q.illegal;
endmodule
